// File: rtl/overflow_sub_serial.sv
// overflow_sub_serial
//    Bit-serial signed subtractor with overflow detection. Computes a - b one
//    bit per clock as a + ~b + 1. Operands arrive over a start valid/ready
//    handshake. The difference and a signed-overflow flag leave over a done
//    valid/ready handshake.
//
//    Build option:
//       SUB_SATURATE_EN  when defined, an overflowing result is clamped to the
//                        most positive value if a >= 0, and to the most
//                        negative value otherwise. overflow is still asserted.
//
// Ports:
//    clk          clock, rising edge
//    rst_n        asynchronous active-low reset
//    start_valid  operands a/b valid
//    start_ready  block can accept operands (IDLE)
//    a, b         minuend / subtrahend, signed WIDTH-bit
//    done_valid   diff/overflow valid (DONE)
//    done_ready   consumer accepts result
//    diff         a - b, signed WIDTH-bit
//    overflow     signed overflow of a - b
//    busy         operation in progress (SHIFT or DONE)
//
// state | meaning
// IDLE  | waiting for operands, start_ready high
// SHIFT | one difference bit per cycle, LSB first, WIDTH cycles
// DONE  | result held with done_valid high until done_ready

module overflow_sub_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] diff,
   output logic             overflow,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             sum_bit;
   logic             carry_out;
   logic [WIDTH-1:0] res_next;
   logic             ovf_next;
   logic [WIDTH-1:0] diff_next;

   // On the last SHIFT cycle, sh_a[0]/sh_b[0] hold the operand MSBs. carry is
   // then the carry into the MSB, so overflow is carry-in xor carry-out there.
   always_comb begin
      sum_bit   = sh_a[0] ^ sh_b[0] ^ carry;
      carry_out = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
      res_next  = {sum_bit, res[WIDTH-1:1]};
      ovf_next  = carry ^ carry_out;
      diff_next = res_next;
`ifdef SUB_SATURATE_EN
      if (ovf_next) begin
         diff_next = sh_a[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sh_a        <= '0;
         sh_b        <= '0;
         res         <= '0;
         carry       <= 1'b0;
         cnt         <= '0;
         diff        <= '0;
         overflow    <= 1'b0;
         start_ready <= 1'b1;
         done_valid  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  sh_a        <= a;
                  sh_b        <= ~b;
                  carry       <= 1'b1;
                  cnt         <= '0;
                  state       <= SHIFT;
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            SHIFT: begin
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               res   <= res_next;
               carry <= carry_out;
               if (cnt == LAST) begin
                  cnt        <= '0;
                  diff       <= diff_next;
                  overflow   <= ovf_next;
                  done_valid <= 1'b1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (done_ready) begin
                  done_valid  <= 1'b0;
                  start_ready <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               start_ready <= 1'b1;
               done_valid  <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_overflow_sub_serial.sv
// Self-checking bench for overflow_sub_serial (WIDTH=8). Expected results are
// computed from the operands when they are accepted and queued. They are
// popped and compared when the DUT presents its result.

module tb_overflow_sub_serial;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             done_valid;
   logic             done_ready;
   logic [WIDTH-1:0] diff;
   logic             overflow;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH:0] exp_q[$];   // {overflow, diff}

   overflow_sub_serial #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .diff        (diff),
      .overflow    (overflow),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] d;
      logic             v;
      d = x - y;
      v = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
`ifdef SUB_SATURATE_EN
      if (v) d = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      return {v, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operand pair, wait for the result, optionally stall done_ready
   // for hold cycles with new operands offered, then complete the handshake.
   task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input int hold);
      int n;
      logic [WIDTH:0] e;
      logic [WIDTH-1:0] d0;
      logic o0;
      n = 0;
      while (!start_ready && n < 20) begin
         tick();
         n++;
      end
      check("start_ready_wait", {31'd0, start_ready}, 32'd1);
      a = xa;
      b = xb;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      exp_q.push_back(model(xa, xb));
      n = 0;
      while (!done_valid && n < 50) begin
         if (start_ready !== 1'b0 || busy !== 1'b1) check("ready_low_in_shift", {30'd0, busy, start_ready}, 32'd2);
         tick();
         n++;
      end
      check("latency", n, WIDTH);
      if (done_valid) begin
         d0 = diff;
         o0 = overflow;
         if (hold > 0) begin
            start_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
               a = WIDTH'($urandom);
               b = WIDTH'($urandom);
               tick();
               check("hold_done_valid", {31'd0, done_valid}, 32'd1);
               check("hold_diff", {24'd0, diff}, {24'd0, d0});
               check("hold_ovf", {31'd0, overflow}, {31'd0, o0});
               check("hold_no_accept", {31'd0, start_ready}, 32'd0);
            end
            start_valid = 1'b0;
         end
         e = exp_q.pop_front();
         check("diff", {24'd0, diff}, {24'd0, e[WIDTH-1:0]});
         check("overflow", {31'd0, overflow}, {31'd0, e[WIDTH]});
         done_ready = 1'b1;
         tick();
         done_ready = 1'b0;
         check("post_done_valid", {31'd0, done_valid}, 32'd0);
         check("post_start_ready", {31'd0, start_ready}, 32'd1);
         check("post_diff_kept", {24'd0, diff}, {24'd0, e[WIDTH-1:0]});
      end else begin
         void'(exp_q.pop_front());
      end
   endtask

   initial begin
      int n;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      done_ready  = 1'b0;
      a           = '0;
      b           = '0;
      #12;
      check("rst_start_ready", {31'd0, start_ready}, 32'd1);
      check("rst_done_valid", {31'd0, done_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_diff", {24'd0, diff}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      do_op(8'h00, 8'h00, 0);
      do_op(8'h05, 8'h07, 0);
      do_op(8'hFF, 8'hFF, 0);
      do_op(8'h80, 8'h01, 0);
      do_op(8'h7F, 8'hFF, 5);
      do_op(8'h3C, 8'hC4, 0);
      do_op(8'hC0, 8'h40, 0);
      do_op(8'hA5, 8'h5A, 2);

      // Abort mid-SHIFT: previous result (nonzero) must be cleared by reset.
      a = 8'h33;
      b = 8'h11;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_done_valid", {31'd0, done_valid}, 32'd0);
      check("abort_start_ready", {31'd0, start_ready}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_diff", {24'd0, diff}, 32'd0);
      check("abort_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done_valid) n++;
      end
      check("abort_no_done", n, 0);

      do_op(8'h10, 8'h20, 0);
      for (int i = 0; i < 6; i++) do_op(WIDTH'($urandom), WIDTH'($urandom), i % 3);

      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
